// File: rtl/tri_fu_mul_seq.sv
`default_nettype none
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 1
`endif
// ============================================================================
// Module   : tri_fu_mul_seq
// Brief    : Slot sequencer/arbiter for the shared 53x54 FPU multiplier.
//            FMA issue owns the ex2 slot. Newton-Raphson divide/sqrt passes
//            fill idle slots. Starved issue is back-pressured via fma_hold.
// Revision : 1.0  initial release
// ============================================================================
module tri_fu_mul_seq #(
  parameter int unsigned STARVE_LIM = 7
) (
  input  logic [0:`NCLK_WIDTH-1] nclk,
  input  logic                   rst,
  input  logic                   ex1_fma_v,
  input  logic                   dsq_start,
  input  logic                   dsq_sqrt,
  input  logic                   dsq_dp,
  input  logic                   dsq_flush,
  output logic                   ex2_act,
  output logic [2:0]             ex2_sel,
  output logic                   ex2_dsq_v,
  output logic                   ex4_res_v,
  output logic [2:0]             ex4_res_code,
  output logic                   dsq_busy,
  output logic                   dsq_done,
  output logic                   fma_hold,
  output logic [3:0]             dsq_pass_cnt
);

  localparam logic [3:0] C_LIM = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  logic clk;
  assign clk = nclk[0];

  state_t     state_q, state_d;
  logic       wait_q, wait_d;
  logic       sqrt_q, sqrt_d;
  logic       dp_q, dp_d;
  logic [3:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       hold_q, hold_d;

  // ex2..ex4 pass pipeline
  logic       ex2_act_q, ex2_dsq_v_q, ex2_last_q;
  logic [2:0] ex2_sel_q;
  logic       ex3_v_q, ex3_last_q;
  logic [2:0] ex3_code_q;
  logic       ex4_v_q, done_q;
  logic [2:0] ex4_code_q;

  logic       grant;
  logic [2:0] cur_code;
  logic       cur_last;

  // Operand pass code for pass number idx of the current sequence.
  function automatic logic [2:0] pass_code(input logic sqrt, input logic dp,
                                           input logic [3:0] idx);
    logic [2:0] code;
    logic [3:0] n_iter;
    code = 3'b000;
    if (!sqrt) begin
      n_iter = dp ? 4'd6 : 4'd4;
      if (idx < n_iter)       code = idx[0] ? 3'b010 : 3'b001;
      else if (idx == n_iter) code = 3'b011;
      else                    code = 3'b100;
    end else begin
      n_iter = dp ? 4'd9 : 4'd6;
      if (idx < n_iter) begin
        case (idx)
          4'd0, 4'd3, 4'd6: code = 3'b101;
          4'd1, 4'd4, 4'd7: code = 3'b110;
          default:          code = 3'b010;
        endcase
      end else if (idx == n_iter) begin
        code = 3'b111;
      end else begin
        code = 3'b101;
      end
    end
    return code;
  endfunction

  // True when idx is the final pass of the sequence.
  function automatic logic pass_last(input logic sqrt, input logic dp,
                                     input logic [3:0] idx);
    logic [3:0] total;
    total = sqrt ? (dp ? 4'd11 : 4'd8) : (dp ? 4'd8 : 4'd6);
    return idx == (total - 4'd1);
  endfunction

  assign cur_code = pass_code(sqrt_q, dp_q, pass_cnt_q);
  assign cur_last = pass_last(sqrt_q, dp_q, pass_cnt_q);

  // A flush in the grant cycle cancels the pass before it reaches the array.
  assign grant = (state_q == ST_READY) & ~ex1_fma_v & ~dsq_flush;

  // Next-state: sequence FSM, pass counter, starvation counter and hold.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    sqrt_d     = sqrt_q;
    dp_d       = dp_q;
    pass_cnt_d = pass_cnt_q;
    starve_d   = 4'd0;
    hold_d     = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (dsq_start) begin
          state_d    = ST_READY;
          sqrt_d     = dsq_sqrt;
          dp_d       = dsq_dp;
          pass_cnt_d = 4'd0;
        end
      end
      ST_READY: begin
        if (grant) begin
          pass_cnt_d = pass_cnt_q + 4'd1;
          state_d    = cur_last ? ST_DRAIN : ST_WAIT;
          wait_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_q) state_d = ST_READY;
        else        wait_d  = 1'b1;
      end
      ST_DRAIN: begin
        if (ex4_v_q & done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Count denied READY cycles; saturate so a long FMA burst cannot wrap.
    if ((state_q == ST_READY) & ex1_fma_v) begin
      starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
      if (starve_d >= C_LIM) hold_d = 1'b1;
    end
    if (grant) hold_d = 1'b0;

    if (dsq_flush) begin
      state_d    = ST_IDLE;
      wait_d     = 1'b0;
      pass_cnt_d = 4'd0;
      starve_d   = 4'd0;
      hold_d     = 1'b0;
    end
  end

  // State and pass pipeline registers; flush drops in-flight returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= 1'b0;
      sqrt_q      <= 1'b0;
      dp_q        <= 1'b0;
      pass_cnt_q  <= 4'd0;
      starve_q    <= 4'd0;
      hold_q      <= 1'b0;
      ex2_act_q   <= 1'b0;
      ex2_sel_q   <= 3'b000;
      ex2_dsq_v_q <= 1'b0;
      ex2_last_q  <= 1'b0;
      ex3_v_q     <= 1'b0;
      ex3_code_q  <= 3'b000;
      ex3_last_q  <= 1'b0;
      ex4_v_q     <= 1'b0;
      ex4_code_q  <= 3'b000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sqrt_q      <= sqrt_d;
      dp_q        <= dp_d;
      pass_cnt_q  <= pass_cnt_d;
      starve_q    <= starve_d;
      hold_q      <= hold_d;
      ex2_act_q   <= ex1_fma_v | grant;
      ex2_sel_q   <= grant ? cur_code : 3'b000;
      ex2_dsq_v_q <= grant;
      ex2_last_q  <= grant & cur_last;
      ex3_v_q     <= ex2_dsq_v_q & ~dsq_flush;
      ex3_code_q  <= (ex2_dsq_v_q & ~dsq_flush) ? ex2_sel_q : 3'b000;
      ex3_last_q  <= ex2_last_q & ~dsq_flush;
      ex4_v_q     <= ex3_v_q & ~dsq_flush;
      ex4_code_q  <= (ex3_v_q & ~dsq_flush) ? ex3_code_q : 3'b000;
      done_q      <= ex3_v_q & ex3_last_q & ~dsq_flush;
    end
  end

  assign ex2_act      = ex2_act_q;
  assign ex2_sel      = ex2_sel_q;
  assign ex2_dsq_v    = ex2_dsq_v_q;
  assign ex4_res_v    = ex4_v_q;
  assign ex4_res_code = ex4_code_q;
  assign dsq_busy     = (state_q != ST_IDLE);
  assign dsq_done     = done_q;
  assign fma_hold     = hold_q;
  assign dsq_pass_cnt = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_fu_mul_seq.sv
`default_nettype none
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 1
`endif
// ============================================================================
// Module   : tb_tri_fu_mul_seq
// Brief    : Directed bench for tri_fu_mul_seq: full sequences from a vector
//            table plus hand-written starvation/flush/collision/reset cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_tri_fu_mul_seq;

  logic [0:`NCLK_WIDTH-1] nclk;
  logic       rst, ex1_fma_v, dsq_start, dsq_sqrt, dsq_dp, dsq_flush;
  logic       ex2_act, ex2_dsq_v, ex4_res_v, dsq_busy, dsq_done, fma_hold;
  logic [2:0] ex2_sel, ex4_res_code;
  logic [3:0] dsq_pass_cnt;

  int n_vec = 0;
  int n_err = 0;

  tri_fu_mul_seq #(.STARVE_LIM(7)) dut (
    .nclk(nclk), .rst(rst), .ex1_fma_v(ex1_fma_v), .dsq_start(dsq_start),
    .dsq_sqrt(dsq_sqrt), .dsq_dp(dsq_dp), .dsq_flush(dsq_flush),
    .ex2_act(ex2_act), .ex2_sel(ex2_sel), .ex2_dsq_v(ex2_dsq_v),
    .ex4_res_v(ex4_res_v), .ex4_res_code(ex4_res_code), .dsq_busy(dsq_busy),
    .dsq_done(dsq_done), .fma_hold(fma_hold), .dsq_pass_cnt(dsq_pass_cnt)
  );

  initial nclk = '0;
  always #5 nclk[0] = ~nclk[0];

  // {act, sel[2:0], dsq_v, res_v, res_code[2:0], busy, done, hold}
  logic [11:0] obs;
  assign obs = {ex2_act, ex2_sel, ex2_dsq_v, ex4_res_v, ex4_res_code,
                dsq_busy, dsq_done, fma_hold};

  typedef struct {
    logic        sqrt;
    logic        dp;
    int          npass;
    logic [32:0] codes;   // pass codes, first pass in the top 3 bits
    int          done;    // cycle of dsq_done
    int          xstart;  // cycle of an extra start while busy (-1 = none)
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge nclk[0]);
    #1;
  endtask

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ex1_fma_v = 1'b0; dsq_start = 1'b0; dsq_sqrt = 1'b0;
    dsq_dp = 1'b0; dsq_flush = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic        e_dv, e_rv, e_act, e_busy, e_done;
    logic [2:0]  e_sel, e_rc;
    logic [11:0] exp;

    vecs[0] = '{1'b0, 1'b0, 6,
                {3'b001,3'b010,3'b001,3'b010,3'b011,3'b100, 15'b0}, 19, -1};
    vecs[1] = '{1'b0, 1'b1, 8,
                {3'b001,3'b010,3'b001,3'b010,3'b001,3'b010,3'b011,3'b100, 9'b0}, 25, -1};
    vecs[2] = '{1'b1, 1'b0, 8,
                {3'b101,3'b110,3'b010,3'b101,3'b110,3'b010,3'b111,3'b101, 9'b0}, 25, -1};
    vecs[3] = '{1'b1, 1'b1, 11,
                {3'b101,3'b110,3'b010,3'b101,3'b110,3'b010,3'b101,3'b110,3'b010,
                 3'b111,3'b101}, 34, -1};
    vecs[4] = '{1'b0, 1'b0, 6,
                {3'b001,3'b010,3'b001,3'b010,3'b011,3'b100, 15'b0}, 19, 3};

    // Reset state
    do_reset();
    check("reset_outputs", obs, 12'b0);
    check("reset_pass_cnt", {8'b0, dsq_pass_cnt}, 12'd0);

    // Full sequences, no FMA traffic
    for (int r = 0; r < 5; r++) begin
      do_reset();
      dsq_start = 1'b1; dsq_sqrt = vecs[r].sqrt; dsq_dp = vecs[r].dp;
      for (int t = 1; t <= vecs[r].done + 2; t++) begin
        step();
        dsq_start = (t == vecs[r].xstart);
        dsq_sqrt  = 1'b1;
        dsq_dp    = 1'b1;
        e_dv  = (t >= 2) && ((t - 2) % 3 == 0) && ((t - 2) / 3 < vecs[r].npass);
        e_sel = e_dv ? vecs[r].codes[32 - 3*((t - 2) / 3) -: 3] : 3'b000;
        e_rv  = (t >= 4) && ((t - 4) % 3 == 0) && ((t - 4) / 3 < vecs[r].npass);
        e_rc  = e_rv ? vecs[r].codes[32 - 3*((t - 4) / 3) -: 3] : 3'b000;
        e_busy = (t <= vecs[r].done);
        e_done = (t == vecs[r].done);
        exp = {e_dv, e_sel, e_dv, e_rv, e_rc, e_busy, e_done, 1'b0};
        check($sformatf("vec%0d_cyc%0d", r, t), obs, exp);
      end
      check($sformatf("vec%0d_pass_cnt", r), {8'b0, dsq_pass_cnt},
            12'(vecs[r].npass));
    end

    // Starvation: FMA every cycle 1..7, hold at 8, grant at 8
    do_reset();
    dsq_start = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      step();
      dsq_start = 1'b0;
      e_act = (t >= 2) && (t <= 9);
      e_sel = (t == 9) ? 3'b001 : 3'b000;
      e_rc  = (t == 11) ? 3'b001 : 3'b000;
      exp = {e_act, e_sel, (t == 9), (t == 11), e_rc, 1'b1, 1'b0, (t == 8)};
      check($sformatf("starve_cyc%0d", t), obs, exp);
      ex1_fma_v = (t <= 7);
    end

    // Flush after grant at 4; restart at 6 grants at 7
    do_reset();
    dsq_start = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      e_act = ((t >= 2) && (t <= 5)) || (t == 8);
      e_sel = ((t == 5) || (t == 8)) ? 3'b001 : 3'b000;
      e_rc  = (t == 10) ? 3'b001 : 3'b000;
      exp = {e_act, e_sel, (t == 5) || (t == 8), (t == 10), e_rc, (t != 6),
             1'b0, 1'b0};
      check($sformatf("flush_cyc%0d", t), obs, exp);
      if (t == 6) check("flush_cnt_clear", {8'b0, dsq_pass_cnt}, 12'd0);
      if (t == 8) check("flush_cnt_restart", {8'b0, dsq_pass_cnt}, 12'd1);
      ex1_fma_v = (t <= 3);
      dsq_flush = (t == 5);
      dsq_start = (t == 6);
    end

    // Start and flush together: stays idle
    do_reset();
    dsq_start = 1'b1; dsq_flush = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      step();
      dsq_start = 1'b0; dsq_flush = 1'b0;
      check($sformatf("start_flush_cyc%0d", t), obs, 12'b0);
    end

    // Reset at cycle 9 of a dp divide
    do_reset();
    dsq_start = 1'b1; dsq_dp = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      step();
      dsq_start = 1'b0;
    end
    check("rst_mid_before", obs, 12'b0000_0000_0100);
    check("rst_mid_cnt_before", {8'b0, dsq_pass_cnt}, 12'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outputs", obs, 12'b0);
    check("rst_mid_cnt", {8'b0, dsq_pass_cnt}, 12'd0);
    for (int t = 11; t <= 16; t++) begin
      step();
      check($sformatf("rst_mid_cyc%0d", t), obs, 12'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
